ct_f_spsram_param: RTL and testbench

Parametrised single-port synchronous SRAM wrapper for FPGA builds, replacing the fixed-geometry per-size wrappers (e.g. 64x108). It splits a WIDTH-bit word into SLICES independently write-enabled slices. It holds the last accessed address while the port is idle and zero-fills the array after reset. An optional output register is provided for timing closure. It sits between cache/buffer control logic and the inferred block RAM; the port protocol is the existing active-low CEN/GWEN/WEN convention.

---
 rtl/ct_f_spsram_param.sv | 94 +++++++++
 tb/tb_ct_f_spsram_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_param.sv
// ct_f_spsram_param: parametrised single-port SRAM with per-slice write enables,
// idle address hold, optional output register and post-reset zero fill.
module ct_f_spsram_param #(
    parameter int ADDR_WIDTH = 6,
    parameter int SLICE_W    = 27,
    parameter int SLICES     = 4,
    parameter int OUT_REG    = 0,
    parameter int INIT_EN    = 1
) (
    input  logic                        CLK,
    input  logic                        cpurst_b,
    input  logic [ADDR_WIDTH-1:0]       A,
    input  logic                        CEN,
    input  logic                        GWEN,
    input  logic [SLICE_W*SLICES-1:0]   WEN,
    input  logic [SLICE_W*SLICES-1:0]   D,
    output logic [SLICE_W*SLICES-1:0]   Q,
    output logic                        INIT_DONE
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int WIDTH = SLICE_W*SLICES;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH-1);

    typedef enum logic {INIT, READY} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   init_cnt;
    logic [ADDR_WIDTH-1:0] addr_hold, addr, ram_addr;
    logic [SLICES-1:0]     we;
    logic [WIDTH-1:0]      wdata, ram_q;
    logic                  filling;
    logic                  unused_wen;

    assign INIT_DONE  = state == READY;
    assign filling    = INIT_EN != 0 && state == INIT;
    assign addr       = CEN ? addr_hold : A;
    assign ram_addr   = filling ? init_cnt[ADDR_WIDTH-1:0] : addr;
    assign wdata      = filling ? '0 : D;
    // only the slice MSBs of WEN carry meaning
    assign unused_wen = ^WEN;

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= filling ? init_cnt + 1'b1 : init_cnt;
        end
    end

    always_comb begin
        state_nxt = state;
        state_nxt = (state == INIT && (INIT_EN == 0 || init_cnt == LAST)) ? READY : state;
    end

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b)
            addr_hold <= '0;
        else if (!CEN && INIT_DONE)
            addr_hold <= A;
    end

    for (genvar k = 0; k < SLICES; k++) begin : g_slice
        logic [SLICE_W-1:0] mem [DEPTH];
        logic [SLICE_W-1:0] q_s;
        assign we[k] = filling || (!CEN && !GWEN && !WEN[k*SLICE_W+SLICE_W-1] && INIT_DONE);
        always_ff @(posedge CLK) begin
            if (we[k])
                mem[ram_addr] <= wdata[k*SLICE_W +: SLICE_W];
        end
        // write-first: a written slice returns the new data in the same cycle
        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b)
                q_s <= '0;
            else
                q_s <= we[k] ? wdata[k*SLICE_W +: SLICE_W] : mem[ram_addr];
        end
        assign ram_q[k*SLICE_W +: SLICE_W] = q_s;
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] q_r;
        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b)
                q_r <= '0;
            else
                q_r <= ram_q;
        end
        assign Q = q_r;
    end else begin : g_nreg
        assign Q = ram_q;
    end
endmodule

// File: tb/tb_ct_f_spsram_param.sv
// tb_ct_f_spsram_param: scoreboard bench for default, output-registered and small-geometry SRAM builds.
module tb_ct_f_spsram_param;
    logic         CLK = 1'b0;
    logic         rst_n = 1'b0, rst2_n = 1'b0;
    logic [5:0]   A = '0;
    logic         CEN = 1'b1, GWEN = 1'b1;
    logic [107:0] WEN = '1, D = '0;
    logic [107:0] Q0, Q1;
    logic         done0, done1;
    logic [3:0]   A2 = '0;
    logic         CEN2 = 1'b1, GWEN2 = 1'b1;
    logic [15:0]  WEN2 = '1, D2 = '0, Q2;
    logic         done2;
    int           cyc = 0, n_assert = 0, n_fail = 0;

    typedef struct {
        int           due;
        int           kind;
        logic [107:0] exp;
        string        name;
    } exp_t;
    exp_t sbq[$];
    logic [107:0] mon_act;

    ct_f_spsram_param dut0 (
        .CLK(CLK), .cpurst_b(rst_n), .A(A), .CEN(CEN), .GWEN(GWEN),
        .WEN(WEN), .D(D), .Q(Q0), .INIT_DONE(done0));

    ct_f_spsram_param #(.OUT_REG(1)) dut1 (
        .CLK(CLK), .cpurst_b(rst_n), .A(A), .CEN(CEN), .GWEN(GWEN),
        .WEN(WEN), .D(D), .Q(Q1), .INIT_DONE(done1));

    ct_f_spsram_param #(.ADDR_WIDTH(4), .SLICE_W(8), .SLICES(2), .INIT_EN(0)) dut2 (
        .CLK(CLK), .cpurst_b(rst2_n), .A(A2), .CEN(CEN2), .GWEN(GWEN2),
        .WEN(WEN2), .D(D2), .Q(Q2), .INIT_DONE(done2));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [107:0] pick(int k);
        return k == 0 ? Q0 : k == 1 ? Q1 : k == 2 ? 108'(done0) :
               k == 3 ? 108'(done1) : k == 4 ? 108'(Q2) : 108'(done2);
    endfunction

    // kinds: 0 Q0, 1 Q1, 2 done0, 3 done1, 4 Q2, 5 done2
    always @(negedge CLK) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due <= cyc) begin
                mon_act = pick(sbq[i].kind);
                n_assert++;
                if (mon_act !== sbq[i].exp) begin
                    n_fail++;
                    $display("FAIL %s (kind %0d, cycle %0d): got %h, expected %h",
                             sbq[i].name, sbq[i].kind, cyc, mon_act, sbq[i].exp);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic push(int kind, int due, logic [107:0] e, string nm);
        sbq.push_back('{due, kind, e, nm});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(logic [5:0] a, logic [107:0] e, string nm);
        A = a; CEN = 1'b0; GWEN = 1'b1; WEN = '1;
        tick();
        push(0, cyc, e, nm);
        push(1, cyc + 1, e, nm);
    endtask

    task automatic wr(logic [5:0] a, logic [107:0] d, logic [107:0] w, logic [107:0] e, string nm);
        A = a; CEN = 1'b0; GWEN = 1'b0; WEN = w; D = d;
        tick();
        push(0, cyc, e, nm);
        push(1, cyc + 1, e, nm);
    endtask

    task automatic idle();
        CEN = 1'b1; GWEN = 1'b1; WEN = '1;
        tick();
    endtask

    task automatic op2(logic [3:0] a, logic wr_en, logic [15:0] d, logic [15:0] w, logic [15:0] e, string nm);
        A2 = a; CEN2 = 1'b0; GWEN2 = !wr_en; WEN2 = w; D2 = d;
        tick();
        push(4, cyc, 108'(e), nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [107:0] ones, wen_m, wen_ign, e5, pat;
        int r2;
        ones    = '1;
        wen_m   = '1;
        wen_m[26] = 1'b0;
        wen_m[80] = 1'b0;
        wen_ign = '0;
        for (int k = 0; k < 4; k++) wen_ign[k*27+26] = 1'b1;
        e5  = {27'h0, 27'h7FFFFFF, 27'h0, 27'h7FFFFFF};
        pat = 108'h123456789ABCDEF0123456789;

        tick(); tick();
        push(0, cyc, '0, "reset_q0");
        push(1, cyc, '0, "reset_q1");
        push(2, cyc, '0, "reset_done0");
        push(3, cyc, '0, "reset_done1");
        push(4, cyc, '0, "reset_q2");
        push(5, cyc, '0, "reset_done2");

        rst_n = 1'b1;
        repeat (20) tick();
        rst_n = 1'b0;
        push(0, cyc, '0, "midinit_rst_q0");
        push(2, cyc, '0, "midinit_rst_done0");
        push(3, cyc, '0, "midinit_rst_done1");
        tick(); tick();

        rst_n = 1'b1;
        r2 = cyc;
        push(0, r2 + 10, '0, "init_fill_q0");
        push(2, r2 + 63, '0, "init_done0_early");
        push(2, r2 + 64, 108'd1, "init_done0_rise");
        push(3, r2 + 63, '0, "init_done1_early");
        push(3, r2 + 64, 108'd1, "init_done1_rise");
        for (int i = 1; i <= 64; i++) begin
            if (i == 5) begin
                A = 6'd7; CEN = 1'b0; GWEN = 1'b0; WEN = '0; D = ones;
            end else begin
                CEN = 1'b1; GWEN = 1'b1; WEN = '1;
            end
            tick();
        end

        rd(6'd0,  '0, "fill_rd0");
        rd(6'd31, '0, "fill_rd31");
        rd(6'd63, '0, "fill_rd63");
        rd(6'd7,  '0, "dropped_write_rd7");

        wr(6'd5, ones, wen_m, e5, "mask_wr5");
        wr(6'd5, '0, wen_ign, e5, "nonmsb_wen_ignored");
        rd(6'd5, e5, "mask_rd5");

        wr(6'd9, pat, '0, pat, "wr9");
        rd(6'd9, pat, "rd9");
        for (int i = 0; i < 10; i++) begin
            A = 6'($urandom); CEN = 1'b1; GWEN = 1'b0; WEN = '0;
            D = 108'({$urandom, $urandom, $urandom, $urandom});
            tick();
            push(0, cyc, pat, "hold_q0");
            push(1, cyc + 1, pat, "hold_q1");
        end

        wr(6'd3, 108'h1234, '0, 108'h1234, "wf_wr3");
        rd(6'd3, 108'h1234, "wf_rd3");
        idle();
        idle();
        #2;
        rst_n = 1'b0;
        push(0, cyc, '0, "async_rst_q0");
        push(1, cyc, '0, "async_rst_q1");
        push(2, cyc, '0, "async_rst_done0");
        push(3, cyc, '0, "async_rst_done1");
        tick();

        rst2_n = 1'b1;
        push(5, cyc, '0, "ng_done_before_edge");
        push(5, cyc + 1, 108'd1, "ng_done_one_edge");
        tick();
        op2(4'd15, 1'b1, 16'h0000, 16'h0000, 16'h0000, "ng_clr15");
        op2(4'd0,  1'b1, 16'h0000, 16'h0000, 16'h0000, "ng_clr0");
        op2(4'd15, 1'b1, 16'hA53C, 16'h0080, 16'hA500, "ng_slice1_wr");
        op2(4'd15, 1'b0, 16'h0000, 16'hFFFF, 16'hA500, "ng_rd15");
        op2(4'd0,  1'b0, 16'h0000, 16'hFFFF, 16'h0000, "ng_no_alias_rd0");
        CEN2 = 1'b1; GWEN2 = 1'b1; WEN2 = '1;
        repeat (3) tick();

        n_assert++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
